// File: rtl/cdb_pkg.sv
// Shared constants for the common-data-bus arbiter slice.
// Combinational only; no latency.
// No flow control here; constants only.
package cdb_pkg;
    // ROB tag width and CDB payload width used by the result producers.
    localparam int ROB_SIZE_BIT  = 4;
    localparam int CDB_DATA_W    = 32;
    localparam int BUF_DEPTH_DEF = 4;

    // Round-robin priority pointer encoding.
    localparam logic PRIO_ALU = 1'b0;
    localparam logic PRIO_LSB = 1'b1;
endpackage

// File: rtl/cdb_src_fifo.sv
// In-order result buffer for one CDB source ({value, rob_id} payload).
// Head is visible combinationally; push/pop take effect at the next edge.
// Caller must not push when full or pop when empty; en_i low freezes all state.
// Ports: clk_i/rst_i (sync, active-high), en_i (global ready), clear_i (flush),
//        push_i/push_dat_i, pop_i, head_o, count_o, full_o, empty_o.
module cdb_src_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 36
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         en_i,
    input  logic                         clear_i,
    input  logic                         push_i,
    input  logic [W-1:0]                 push_dat_i,
    input  logic                         pop_i,
    output logic [W-1:0]                 head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign do_push = en_i && !clear_i && push_i;
    assign do_pop  = en_i && !clear_i && pop_i;

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (en_i && clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow.
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (!rst_i && do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end
endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter putting ALU and LSB results onto one registered CDB.
// Latency: an uncontested result with an empty buffer is on the CDB 1 cycle after fi.
// Backpressure: per-source full flags from registered buffer counts; rdy_in low freezes all.
// Ports: clk_in, rst_in (sync, active-high), rdy_in, rob_clear (flush);
//        alu_fi/alu_value/alu_rob_id -> alu_full; lsb_fi/lsb_value/lsb_rob_id -> lsb_full;
//        cdb_fi/cdb_value/cdb_rob_id registered broadcast snooped by RS, LSB and ROB.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int ROB_IDX_W = ROB_SIZE_BIT,
    parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  rob_clear,
    input  logic                  alu_fi,
    input  logic [CDB_DATA_W-1:0] alu_value,
    input  logic [ROB_IDX_W-1:0]  alu_rob_id,
    output logic                  alu_full,
    input  logic                  lsb_fi,
    input  logic [CDB_DATA_W-1:0] lsb_value,
    input  logic [ROB_IDX_W-1:0]  lsb_rob_id,
    output logic                  lsb_full,
    output logic                  cdb_fi,
    output logic [CDB_DATA_W-1:0] cdb_value,
    output logic [ROB_IDX_W-1:0]  cdb_rob_id
);
    localparam int PW = CDB_DATA_W + ROB_IDX_W;
    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic [PW-1:0] alu_head, lsb_head, alu_cand_dat, lsb_cand_dat;
    logic [CW-1:0] alu_cnt, lsb_cnt;
    logic          alu_buf_full, lsb_buf_full, alu_empty, lsb_empty;
    logic          alu_acc, lsb_acc, alu_cand, lsb_cand;
    logic          gnt_alu, gnt_lsb, contested;
    logic          alu_push, lsb_push, alu_pop, lsb_pop;

    logic          prio_q, prio_d;
    logic          cdb_fi_q, cdb_fi_d;
    logic [PW-1:0] cdb_dat_q, cdb_dat_d;

    // Full flags come straight from the registered counts.
    assign alu_full = (alu_cnt == CW'(BUF_DEPTH));
    assign lsb_full = (lsb_cnt == CW'(BUF_DEPTH));

    // A result offered while full is a protocol violation and is dropped.
    assign alu_acc = alu_fi && !alu_buf_full;
    assign lsb_acc = lsb_fi && !lsb_buf_full;

    // Bypass only with an empty buffer, so per-source order is never reordered.
    assign alu_cand     = !alu_empty || alu_acc;
    assign lsb_cand     = !lsb_empty || lsb_acc;
    assign alu_cand_dat = alu_empty ? {alu_value, alu_rob_id} : alu_head;
    assign lsb_cand_dat = lsb_empty ? {lsb_value, lsb_rob_id} : lsb_head;

    assign contested = alu_cand && lsb_cand;
    assign gnt_alu   = alu_cand && (!lsb_cand || prio_q == PRIO_ALU);
    assign gnt_lsb   = lsb_cand && !gnt_alu;

    // Incoming results are buffered unless they were bypassed straight onto the CDB.
    assign alu_pop  = gnt_alu && !alu_empty;
    assign lsb_pop  = gnt_lsb && !lsb_empty;
    assign alu_push = alu_acc && !(alu_empty && gnt_alu);
    assign lsb_push = lsb_acc && !(lsb_empty && gnt_lsb);

    cdb_src_fifo #(.DEPTH(BUF_DEPTH), .W(PW)) u_alu_fifo (
        .clk_i      (clk_in),
        .rst_i      (rst_in),
        .en_i       (rdy_in),
        .clear_i    (rob_clear),
        .push_i     (alu_push),
        .push_dat_i ({alu_value, alu_rob_id}),
        .pop_i      (alu_pop),
        .head_o     (alu_head),
        .count_o    (alu_cnt),
        .full_o     (alu_buf_full),
        .empty_o    (alu_empty)
    );

    cdb_src_fifo #(.DEPTH(BUF_DEPTH), .W(PW)) u_lsb_fifo (
        .clk_i      (clk_in),
        .rst_i      (rst_in),
        .en_i       (rdy_in),
        .clear_i    (rob_clear),
        .push_i     (lsb_push),
        .push_dat_i ({lsb_value, lsb_rob_id}),
        .pop_i      (lsb_pop),
        .head_o     (lsb_head),
        .count_o    (lsb_cnt),
        .full_o     (lsb_buf_full),
        .empty_o    (lsb_empty)
    );

    always_comb begin
        prio_d    = prio_q;
        cdb_fi_d  = cdb_fi_q;
        cdb_dat_d = cdb_dat_q;
        if (rdy_in) begin
            if (rob_clear) begin
                prio_d   = PRIO_ALU;
                cdb_fi_d = 1'b0;
            end else begin
                cdb_fi_d = gnt_alu || gnt_lsb;
                if (gnt_alu)      cdb_dat_d = alu_cand_dat;
                else if (gnt_lsb) cdb_dat_d = lsb_cand_dat;
                // Pointer only moves when both sources actually competed.
                if (contested)    prio_d    = ~prio_q;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            prio_q    <= PRIO_ALU;
            cdb_fi_q  <= 1'b0;
            cdb_dat_q <= '0;
        end else begin
            prio_q    <= prio_d;
            cdb_fi_q  <= cdb_fi_d;
            cdb_dat_q <= cdb_dat_d;
        end
    end

    assign cdb_fi                  = cdb_fi_q;
    assign {cdb_value, cdb_rob_id} = cdb_dat_q;

    // Producers must honour their full flag.
    a_alu_no_overflow: assert property (@(posedge clk_in) disable iff (rst_in)
        (rdy_in && !rob_clear) |-> !(alu_fi && alu_full));
    a_lsb_no_overflow: assert property (@(posedge clk_in) disable iff (rst_in)
        (rdy_in && !rob_clear) |-> !(lsb_fi && lsb_full));
endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int RW    = ROB_SIZE_BIT;
    localparam int DEPTH = BUF_DEPTH_DEF;

    logic          clk_in = 1'b0;
    logic          rst_in, rdy_in, rob_clear;
    logic          alu_fi, lsb_fi;
    logic [31:0]   alu_value, lsb_value;
    logic [RW-1:0] alu_rob_id, lsb_rob_id;
    logic          alu_full, lsb_full, cdb_fi;
    logic [31:0]   cdb_value;
    logic [RW-1:0] cdb_rob_id;

    always #5 clk_in = ~clk_in;

    cdb_arbiter #(.ROB_IDX_W(RW), .BUF_DEPTH(DEPTH)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .rob_clear  (rob_clear),
        .alu_fi     (alu_fi),
        .alu_value  (alu_value),
        .alu_rob_id (alu_rob_id),
        .alu_full   (alu_full),
        .lsb_fi     (lsb_fi),
        .lsb_value  (lsb_value),
        .lsb_rob_id (lsb_rob_id),
        .lsb_full   (lsb_full),
        .cdb_fi     (cdb_fi),
        .cdb_value  (cdb_value),
        .cdb_rob_id (cdb_rob_id)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Behavioural model: each source is a queue of pending results. An incoming
    // result joins the back of its queue; the front of each non-empty queue competes.
    logic [32+RW-1:0] aq[$];
    logic [32+RW-1:0] lq[$];
    logic             m_ptr = 1'b0;   // 0: ALU wins a tie, 1: LSB wins a tie
    logic             m_fi  = 1'b0;
    logic [31:0]      m_val = '0;
    logic [RW-1:0]    m_tag = '0;

    task automatic model_step(input logic r, input logic rd, input logic cl,
                              input logic af, input logic [31:0] av, input logic [RW-1:0] at,
                              input logic lf, input logic [31:0] lv, input logic [RW-1:0] lt);
        logic [32+RW-1:0] e;
        bit a, l;
        e = '0;
        if (r) begin
            aq.delete(); lq.delete();
            m_ptr = 1'b0; m_fi = 1'b0; m_val = '0; m_tag = '0;
        end else if (rd) begin
            if (cl) begin
                aq.delete(); lq.delete();
                m_ptr = 1'b0; m_fi = 1'b0;
            end else begin
                if (af && aq.size() < DEPTH) aq.push_back({av, at});
                if (lf && lq.size() < DEPTH) lq.push_back({lv, lt});
                a = aq.size() > 0;
                l = lq.size() > 0;
                m_fi = a || l;
                if (a && (!l || m_ptr == 1'b0)) e = aq.pop_front();
                else if (l)                     e = lq.pop_front();
                if (a && l) m_ptr = ~m_ptr;
                if (m_fi) {m_val, m_tag} = e;
            end
        end
    endtask

    // Every negedge: DUT outputs must match the model.
    always @(negedge clk_in) begin
        check("cdb_fi", cdb_fi, m_fi);
        if (m_fi) begin
            check("cdb_value", cdb_value, m_val);
            check("cdb_rob_id", cdb_rob_id, m_tag);
        end
        check("alu_full", alu_full, aq.size() == DEPTH);
        check("lsb_full", lsb_full, lq.size() == DEPTH);
    end

    task automatic tick(input logic r, input logic rd, input logic cl,
                        input logic af, input logic [31:0] av, input logic [RW-1:0] at,
                        input logic lf, input logic [31:0] lv, input logic [RW-1:0] lt);
        rst_in = r; rdy_in = rd; rob_clear = cl;
        alu_fi = af; alu_value = av; alu_rob_id = at;
        lsb_fi = lf; lsb_value = lv; lsb_rob_id = lt;
        @(posedge clk_in);
        model_step(r, rd, cl, af, av, at, lf, lv, lt);
        @(negedge clk_in);
    endtask

    task automatic drive(input logic af, input logic [31:0] av, input logic [RW-1:0] at,
                         input logic lf, input logic [31:0] lv, input logic [RW-1:0] lt);
        tick(1'b0, 1'b1, 1'b0, af, av, at, lf, lv, lt);
    endtask

    task automatic idle();
        tick(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // Stream-test bookkeeping: ALU values are 0xA000_00nn, LSB values 0xB000_00nn.
    int bcast_cnt, a_next, l_next;

    task automatic note_bcast();
        if (cdb_fi === 1'b1) begin
            bcast_cnt++;
            if (cdb_value[31:28] == 4'hA) begin
                check("t3_alu_order", cdb_value[7:0], a_next[7:0]);
                a_next++;
            end else begin
                check("t3_lsb_order", cdb_value[7:0], l_next[7:0]);
                l_next++;
            end
        end
    endtask

    initial begin
        int n;
        logic [3:0] prev_src;

        // Reset state
        do_reset();
        do_reset();
        check("rst_cdb_fi", cdb_fi, 1'b0);
        check("rst_cdb_value", cdb_value, 32'h0);
        check("rst_cdb_rob_id", cdb_rob_id, 4'h0);
        check("rst_alu_full", alu_full, 1'b0);
        check("rst_lsb_full", lsb_full, 1'b0);

        // 1: single uncontested ALU result, 1-cycle latency
        drive(1'b1, 32'h1234_5678, 4'd3, 1'b0, '0, '0);
        check("t1_fi", cdb_fi, 1'b1);
        check("t1_value", cdb_value, 32'h1234_5678);
        check("t1_tag", cdb_rob_id, 4'd3);
        idle();
        check("t1_fi_after", cdb_fi, 1'b0);

        // 2: contested, ALU first, then pointer favours LSB
        drive(1'b1, 32'hA, 4'd1, 1'b1, 32'hB, 4'd2);
        check("t2_first_tag", cdb_rob_id, 4'd1);
        idle();
        check("t2_second_tag", cdb_rob_id, 4'd2);
        check("t2_second_value", cdb_value, 32'hB);
        drive(1'b1, 32'hC, 4'd3, 1'b1, 32'hD, 4'd4);
        check("t2_ptr_lsb_tag", cdb_rob_id, 4'd4);
        idle();
        check("t2_then_alu_tag", cdb_rob_id, 4'd3);
        idle();
        check("t2_drained", cdb_fi, 1'b0);

        // 3: both sources stream until a full flag rises, then drain
        do_reset();
        n = 0; bcast_cnt = 0; a_next = 0; l_next = 0; prev_src = 4'h0;
        for (int i = 0; i < 30; i++) begin
            if (alu_full || lsb_full) break;
            drive(1'b1, 32'hA000_0000 | n, n[RW-1:0], 1'b1, 32'hB000_0000 | n, n[RW-1:0]);
            n++;
            if (n > 1) begin
                checks++;
                if (cdb_value[31:28] != prev_src) passed++;
                else $display("FAIL t3_alternate: source %0h granted twice in a row", prev_src);
            end
            prev_src = cdb_value[31:28];
            note_bcast();
        end
        check("t3_full_rose", alu_full || lsb_full, 1'b1);
        check("t3_fill_cycles", n, 7);
        check("t3_lsb_full", lsb_full, 1'b1);
        for (int i = 0; i < 20; i++) begin
            idle();
            note_bcast();
        end
        check("t3_total", bcast_cnt, 14);
        check("t3_alu_count", a_next, 7);
        check("t3_lsb_count", l_next, 7);

        // 4: flush with three ALU entries buffered
        do_reset();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (aq.size() >= 3) break;
            drive(1'b1, 32'hA000_0000 | n, n[RW-1:0], 1'b1, 32'hB000_0000 | n, n[RW-1:0]);
            n++;
        end
        tick(1'b0, 1'b1, 1'b1, 1'b1, 32'hDEAD, 4'd9, 1'b1, 32'hBEEF, 4'd10);
        check("t4_clear_fi", cdb_fi, 1'b0);
        check("t4_clear_alu_full", alu_full, 1'b0);
        drive(1'b1, 32'h5555_0005, 4'd5, 1'b0, '0, '0);
        check("t4_fresh_fi", cdb_fi, 1'b1);
        check("t4_fresh_tag", cdb_rob_id, 4'd5);
        check("t4_fresh_value", cdb_value, 32'h5555_0005);
        idle();
        check("t4_no_stale", cdb_fi, 1'b0);

        // 5: freeze with two entries pending
        do_reset();
        drive(1'b1, 32'h0000_00A1, 4'd1, 1'b1, 32'h0000_00B1, 4'd2);
        drive(1'b1, 32'h0000_00A2, 4'd3, 1'b1, 32'h0000_00B2, 4'd4);
        check("t5_pre_tag", cdb_rob_id, 4'd2);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD, 4'd9, 1'b1, 32'hBEEF, 4'd10);
            check("t5_frozen_fi", cdb_fi, 1'b1);
            check("t5_frozen_tag", cdb_rob_id, 4'd2);
            check("t5_frozen_value", cdb_value, 32'h0000_00B1);
        end
        idle();
        check("t5_drain1_tag", cdb_rob_id, 4'd3);
        idle();
        check("t5_drain2_tag", cdb_rob_id, 4'd4);
        idle();
        check("t5_drain_done", cdb_fi, 1'b0);

        // 6: reset mid-stream with both buffers non-empty
        for (int i = 0; i < 4; i++)
            drive(1'b1, 32'hA000_0000 | i, 4'(i), 1'b1, 32'hB000_0000 | i, 4'(i + 8));
        tick(1'b1, 1'b1, 1'b0, 1'b1, 32'hDEAD, 4'd9, 1'b1, 32'hBEEF, 4'd10);
        check("t6_rst_fi", cdb_fi, 1'b0);
        check("t6_rst_value", cdb_value, 32'h0);
        check("t6_rst_tag", cdb_rob_id, 4'h0);
        check("t6_rst_alu_full", alu_full, 1'b0);
        check("t6_rst_lsb_full", lsb_full, 1'b0);
        for (int i = 0; i < 5; i++) begin
            idle();
            check("t6_no_stale", cdb_fi, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
